wb_slave_bridge: RTL and testbench

- Wishbone front-end between the management SoC's user-project Wishbone port and two downstream slaves.
- Slave 0 is the debug register block. Slave 1 is a generic user slave.
- Decodes each address, forwards the transaction to the selected slave and returns that slave's ack and data.
- Guarantees the SoC is never hung: unmapped addresses and slaves that never ack are completed with a fixed error data word, and each timeout is counted.

---
 rtl/wb_slave_bridge_if.sv | 15 +
 rtl/wb_slave_bridge.sv | 138 +++++++++++++
 tb/tb_wb_slave_bridge.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/wb_slave_bridge_if.sv
// Upstream Wishbone port of the bridge: the SoC side is the master and
// the bridge is the slave.
interface wb_slave_bridge_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] adr;
  logic [31:0] dat_w;
  logic [31:0] dat_r;
  logic        ack;

  modport master (output cyc, stb, we, sel, adr, dat_w, input dat_r, ack);
  modport slave  (input cyc, stb, we, sel, adr, dat_w, output dat_r, ack);
endinterface

// File: rtl/wb_slave_bridge.sv
// Wishbone front-end: decodes upstream accesses onto two downstream slaves and
// force-completes unmapped or unanswered accesses with a fixed error word.
module wb_slave_bridge #(
  parameter int unsigned TIMEOUT  = 16,
  parameter logic [31:0] S0_BASE  = 32'h3000_0000,
  parameter logic [31:0] S0_MASK  = 32'hFFFF_FFF0,
  parameter logic [31:0] S1_BASE  = 32'h3000_1000,
  parameter logic [31:0] S1_MASK  = 32'hFFFF_F000,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  wb_slave_bridge_if.slave    wbs,
  output logic                m_cyc_o,
  output logic                m_stb_o,
  output logic                m_we_o,
  output logic [3:0]          m_sel_o,
  output logic [31:0]         m_adr_o,
  output logic [31:0]         m_dat_o,
  output logic                s0_sel_o,
  output logic                s1_sel_o,
  input  logic                s0_ack_i,
  input  logic                s1_ack_i,
  input  logic [31:0]         s0_dat_i,
  input  logic [31:0]         s1_dat_i,
  output logic                err_o,
  output logic [7:0]          timeout_cnt_o
);

  // ERR and RESP are the single cycle in which the upstream ack is high.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FWD  = 2'd1;
  localparam logic [1:0] ST_ERR  = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

  logic [1:0]  state;
  logic [15:0] wait_cnt;
  logic        ack_q;
  logic [31:0] dat_q;
  logic        req;
  logic        hit0;
  logic        hit1;
  logic        sel_ack;
  logic [31:0] sel_dat;

  assign wbs.ack   = ack_q;
  assign wbs.dat_r = dat_q;

  assign req     = wbs.cyc & wbs.stb & ~ack_q;
  assign hit0    = (wbs.adr & S0_MASK) == S0_BASE;
  assign hit1    = (wbs.adr & S1_MASK) == S1_BASE;
  assign sel_ack = (s0_sel_o & s0_ack_i) | (s1_sel_o & s1_ack_i);
  assign sel_dat = s0_sel_o ? s0_dat_i : s1_dat_i;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state         <= ST_IDLE;
      wait_cnt      <= '0;
      ack_q         <= 1'b0;
      dat_q         <= '0;
      err_o         <= 1'b0;
      timeout_cnt_o <= '0;
      m_cyc_o       <= 1'b0;
      m_stb_o       <= 1'b0;
      m_we_o        <= 1'b0;
      m_sel_o       <= '0;
      m_adr_o       <= '0;
      m_dat_o       <= '0;
      s0_sel_o      <= 1'b0;
      s1_sel_o      <= 1'b0;
    end else begin
      // Response outputs are single-cycle pulses unless set below.
      ack_q <= 1'b0;
      dat_q <= '0;
      err_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req) begin
            m_adr_o  <= wbs.adr;
            m_dat_o  <= wbs.dat_w;
            m_we_o   <= wbs.we;
            m_sel_o  <= wbs.sel;
            wait_cnt <= '0;
            if (hit0 || hit1) begin
              s0_sel_o <= hit0;
              s1_sel_o <= ~hit0;
              m_cyc_o  <= 1'b1;
              m_stb_o  <= 1'b1;
              state    <= ST_FWD;
            end else begin
              ack_q <= 1'b1;
              dat_q <= ERR_DATA;
              err_o <= 1'b1;
              state <= ST_ERR;
            end
          end
        end
        ST_FWD: begin
          if (!wbs.cyc) begin
            m_cyc_o  <= 1'b0;
            m_stb_o  <= 1'b0;
            s0_sel_o <= 1'b0;
            s1_sel_o <= 1'b0;
            state    <= ST_IDLE;
          end else if (sel_ack) begin
            m_cyc_o  <= 1'b0;
            m_stb_o  <= 1'b0;
            s0_sel_o <= 1'b0;
            s1_sel_o <= 1'b0;
            ack_q    <= 1'b1;
            dat_q    <= m_we_o ? 32'h0 : sel_dat;
            state    <= ST_RESP;
          end else if (wait_cnt == WAIT_LAST) begin
            m_cyc_o  <= 1'b0;
            m_stb_o  <= 1'b0;
            s0_sel_o <= 1'b0;
            s1_sel_o <= 1'b0;
            ack_q    <= 1'b1;
            dat_q    <= ERR_DATA;
            err_o    <= 1'b1;
            if (timeout_cnt_o != 8'hFF)
              timeout_cnt_o <= timeout_cnt_o + 8'd1;
            state    <= ST_RESP;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        ST_ERR, ST_RESP: begin
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_slave_bridge.sv
// Randomized self-checking bench for wb_slave_bridge against a transaction-level
// model of address decode, ack latency, timeout and error reporting.
module tb_wb_slave_bridge;
  localparam int          TO       = 16;
  localparam logic [31:0] S0_BASE  = 32'h3000_0000;
  localparam logic [31:0] S0_MASK  = 32'hFFFF_FFF0;
  localparam logic [31:0] S1_BASE  = 32'h3000_1000;
  localparam logic [31:0] S1_MASK  = 32'hFFFF_F000;
  localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;
  localparam int          NEVER    = 999;

  logic        clk = 1'b0;
  logic        rst;
  logic        m_cyc, m_stb, m_we, s0_sel, s1_sel, s0_ack, s1_ack, err;
  logic [3:0]  m_sel;
  logic [31:0] m_adr, m_dat, s0_dat, s1_dat;
  logic [7:0]  tcnt;

  int n_chk  = 0;
  int n_fail = 0;
  int exp_tcnt = 0;

  wb_slave_bridge_if bus ();

  wb_slave_bridge #(.TIMEOUT(TO)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wbs(bus),
    .m_cyc_o(m_cyc), .m_stb_o(m_stb), .m_we_o(m_we), .m_sel_o(m_sel),
    .m_adr_o(m_adr), .m_dat_o(m_dat), .s0_sel_o(s0_sel), .s1_sel_o(s1_sel),
    .s0_ack_i(s0_ack), .s1_ack_i(s1_ack), .s0_dat_i(s0_dat), .s1_dat_i(s1_dat),
    .err_o(err), .timeout_cnt_o(tcnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at a negedge one cycle after the upstream ack.
  // d = stb cycle in which the selected slave raises ack (1 = first stb cycle).
  task automatic run_txn(input logic [31:0] adr, input logic we, input logic [31:0] wdat,
                         input logic [3:0] sel, input int d, input logic [31:0] rdat);
    int          tgt;
    int          exp_stb, exp_ack;
    logic        exp_err;
    logic [31:0] exp_dat;
    int          stb_cnt = 0;
    int          ack_cyc = 0;
    logic [31:0] got_dat = '0;
    logic        got_err = 1'b0;
    bit          hold_ok = 1'b1;
    bit          route_ok = 1'b1;

    if ((adr & S0_MASK) == S0_BASE)      tgt = 0;
    else if ((adr & S1_MASK) == S1_BASE) tgt = 1;
    else                                 tgt = -1;

    if (tgt < 0) begin
      exp_stb = 0;  exp_ack = 1;      exp_err = 1'b1;
    end else if (d >= 1 && d <= TO) begin
      exp_stb = d;  exp_ack = d + 1;  exp_err = 1'b0;
    end else begin
      exp_stb = TO; exp_ack = TO + 1; exp_err = 1'b1;
    end
    exp_dat = exp_err ? ERR_DATA : (we ? 32'h0 : rdat);
    if (exp_err && tgt >= 0 && exp_tcnt < 255) exp_tcnt++;

    bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = we;
    bus.adr = adr;  bus.dat_w = wdat; bus.sel = sel;

    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (bus.ack) begin
        ack_cyc = c; got_dat = bus.dat_r; got_err = err;
        break;
      end
      if (m_stb) begin
        stb_cnt++;
        if (m_adr !== adr || m_dat !== wdat || m_sel !== sel || m_we !== we || !m_cyc)
          hold_ok = 1'b0;
        if (s0_sel !== (tgt == 0) || s1_sel !== (tgt == 1)) route_ok = 1'b0;
      end else if (m_cyc || s0_sel || s1_sel) begin
        route_ok = 1'b0;
      end
      s0_dat = $urandom; s1_dat = $urandom;
      s0_ack = (tgt == 1) ? 1'($urandom % 2) : 1'b0;
      s1_ack = (tgt == 0) ? 1'($urandom % 2) : 1'b0;
      if (tgt >= 0 && m_stb && stb_cnt == d) begin
        if (tgt == 0) begin s0_ack = 1'b1; s0_dat = rdat; end
        else          begin s1_ack = 1'b1; s1_dat = rdat; end
      end
    end
    bus.cyc = 1'b0; bus.stb = 1'b0; s0_ack = 1'b0; s1_ack = 1'b0;

    chk("ack_cycle", ack_cyc, exp_ack);
    chk("stb_cycles", stb_cnt, exp_stb);
    chk("ack_data", got_dat, exp_dat);
    chk("err_pulse", got_err, exp_err);
    chk("m_hold", hold_ok, 1'b1);
    chk("routing", route_ok, 1'b1);
    @(negedge clk);
    chk("ack_drop", {bus.ack, err, m_cyc}, 3'b000);
    chk("dat_drop", bus.dat_r, 32'h0);
    chk("timeout_cnt", tcnt, exp_tcnt);
  endtask

  initial begin
    bit          ack_seen;
    logic [31:0] a;
    rst = 1'b1;
    bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0; bus.sel = '0; bus.adr = '0; bus.dat_w = '0;
    s0_ack = 1'b0; s1_ack = 1'b0; s0_dat = '0; s1_dat = '0;
    repeat (2) @(negedge clk);
    chk("reset_ctl", {bus.ack, err, m_cyc, m_stb, s0_sel, s1_sel}, 6'b0);
    chk("reset_dat", bus.dat_r, 32'h0);
    chk("reset_tcnt", tcnt, 8'h0);
    chk("reset_adr", m_adr, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    run_txn(32'h3000_0008, 1'b1, 32'h1234_5678, 4'hF, 2, 32'h0);
    run_txn(32'h3000_000C, 1'b0, 32'h0, 4'hF, 2, 32'hCAFE_0001);
    run_txn(32'h4000_0000, 1'b0, 32'h0, 4'hF, 1, 32'h0);
    run_txn(32'h3000_1004, 1'b0, 32'h0, 4'hF, NEVER, 32'h0);
    run_txn(32'h3000_1004, 1'b0, 32'h0, 4'h3, TO, 32'h5555_AAAA);
    run_txn(32'h3000_1008, 1'b0, 32'h0, 4'hC, TO + 1, 32'h1111_2222);
    run_txn(32'h3000_0004, 1'b0, 32'h0, 4'h1, 1, 32'h0BAD_F00D);

    // Upstream abort in the third FWD cycle.
    bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b0; bus.adr = 32'h3000_1010; bus.sel = 4'hF;
    repeat (3) @(negedge clk);
    bus.cyc = 1'b0; bus.stb = 1'b0;
    ack_seen = 1'b0;
    @(negedge clk);
    chk("abort_drop", {m_cyc, m_stb, s1_sel}, 3'b000);
    for (int i = 0; i < 4; i++) begin
      if (bus.ack || err) ack_seen = 1'b1;
      @(negedge clk);
    end
    chk("abort_noack", ack_seen, 1'b0);
    chk("abort_tcnt", tcnt, exp_tcnt);
    run_txn(32'h3000_1020, 1'b0, 32'h0, 4'hF, 3, 32'h7777_0001);

    // Reset while forwarding.
    bus.cyc = 1'b1; bus.stb = 1'b1; bus.adr = 32'h3000_0000; bus.sel = 4'hF;
    repeat (2) @(negedge clk);
    chk("pre_rst_fwd", m_stb, 1'b1);
    rst = 1'b1;
    #1;
    chk("rst_async_ctl", {bus.ack, err, m_cyc, m_stb, s0_sel, s1_sel}, 6'b0);
    chk("rst_async_tcnt", tcnt, 8'h0);
    exp_tcnt = 0;
    bus.cyc = 1'b0; bus.stb = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_idle", {bus.ack, m_cyc}, 2'b00);

    for (int i = 0; i < 300; i++)
      run_txn(S1_BASE | ($urandom % 4096), 1'b0, 32'h0, 4'hF, NEVER, 32'h0);
    chk("tcnt_saturated", tcnt, 8'd255);

    for (int i = 0; i < 150; i++) begin
      case ($urandom % 3)
        0:       a = S0_BASE | ($urandom % 16);
        1:       a = S1_BASE | ($urandom % 4096);
        default: a = $urandom;
      endcase
      run_txn(a, 1'($urandom % 2), $urandom, 4'($urandom), $urandom_range(1, TO + 4), $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
